// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared sizes, state encodings and bit-reverse helper for the FFT output reorder buffer
package fft_pkg;
    localparam int N_PT  = 256;
    localparam int LOG2N = 8;
    localparam int DW    = 16;

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wr_state_t;
    typedef enum logic       {R_EMPTY, R_DRAIN}       rd_state_t;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = x[LOG2N-1-i];
        end
        return r;
    endfunction
endpackage

// File: rtl/fft_pp_bank.sv
// rtl/fft_pp_bank.sv - one half of the ping-pong frame store: sync write, async read
module fft_pp_bank #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int W     = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/fft_out_reorder.sv
// rtl/fft_out_reorder.sv - captures bit-reversed FFT frames into a ping-pong store, replays them in natural order
module fft_out_reorder
    import fft_pkg::*;
#(
    parameter int BIT_REV = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [DW-1:0]    in_real,
    input  logic [DW-1:0]    in_img,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [DW-1:0]    out_real,
    output logic [DW-1:0]    out_img,
    output logic             out_last,
    output logic [LOG2N-1:0] out_idx,
    output logic             overflow
);
    localparam logic [LOG2N-1:0] LAST = LOG2N'(N_PT - 1);

    wr_state_t        wr_state, wr_state_nxt;
    rd_state_t        rd_state, rd_state_nxt;
    logic [LOG2N-1:0] wr_cnt, wr_cnt_nxt, rd_cnt, rd_cnt_nxt, wr_addr;
    logic             wr_bank, wr_bank_nxt, rd_bank, rd_bank_nxt;
    logic [1:0]       full, full_nxt;
    logic             overflow_nxt;
    logic             we, wr_done, hs, rd_done, bank_free;
    logic [2*DW-1:0]  bank_rdata [2];

    always_comb begin
        hs      = out_valid && out_ready;
        rd_done = hs && (rd_cnt == LAST);
        // A bank released by this cycle's final read may be claimed by a frame starting now.
        bank_free = !full[wr_bank] || (rd_done && (rd_bank == wr_bank));

        wr_state_nxt = wr_state;
        wr_cnt_nxt   = wr_cnt;
        wr_bank_nxt  = wr_bank;
        overflow_nxt = overflow;
        we           = 1'b0;
        wr_done      = 1'b0;
        case (wr_state)
            W_IDLE: if (in_valid) begin
                wr_cnt_nxt = LOG2N'(1);
                if (bank_free) begin
                    we           = 1'b1;
                    wr_state_nxt = W_FILL;
                end else begin
                    overflow_nxt = 1'b1;
                    wr_state_nxt = W_DROP;
                end
            end
            W_FILL: if (in_valid) begin
                we         = 1'b1;
                wr_cnt_nxt = wr_cnt + 1'b1;
                if (wr_cnt == LAST) begin
                    wr_done      = 1'b1;
                    wr_bank_nxt  = ~wr_bank;
                    wr_state_nxt = W_IDLE;
                end
            end
            W_DROP: if (in_valid) begin
                wr_cnt_nxt = wr_cnt + 1'b1;
                if (wr_cnt == LAST) begin
                    wr_state_nxt = W_IDLE;
                end
            end
            default: wr_state_nxt = W_IDLE;
        endcase

        // Filling and draining always target different banks, so both updates can apply together.
        full_nxt = full;
        if (rd_done) full_nxt[rd_bank] = 1'b0;
        if (wr_done) full_nxt[wr_bank] = 1'b1;

        rd_cnt_nxt   = hs ? rd_cnt + 1'b1 : rd_cnt;
        rd_bank_nxt  = rd_done ? ~rd_bank : rd_bank;
        rd_state_nxt = full_nxt[rd_bank_nxt] ? R_DRAIN : R_EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state <= W_IDLE;
            rd_state <= R_EMPTY;
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            full     <= '0;
            overflow <= 1'b0;
        end else begin
            wr_state <= wr_state_nxt;
            rd_state <= rd_state_nxt;
            wr_cnt   <= wr_cnt_nxt;
            rd_cnt   <= rd_cnt_nxt;
            wr_bank  <= wr_bank_nxt;
            rd_bank  <= rd_bank_nxt;
            full     <= full_nxt;
            overflow <= overflow_nxt;
        end
    end

    assign wr_addr = (BIT_REV != 0) ? bitrev(wr_cnt) : wr_cnt;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_pp_bank #(
            .DEPTH (N_PT),
            .AW    (LOG2N),
            .W     (2*DW)
        ) u_bank (
            .clk   (clk),
            .we    (we && (wr_bank == 1'(b))),
            .waddr (wr_addr),
            .wdata ({in_real, in_img}),
            .raddr (rd_cnt),
            .rdata (bank_rdata[b])
        );
    end

    assign out_valid = (rd_state == R_DRAIN);
    assign out_real  = out_valid ? bank_rdata[rd_bank][2*DW-1:DW] : '0;
    assign out_img   = out_valid ? bank_rdata[rd_bank][DW-1:0]    : '0;
    assign out_idx   = out_valid ? rd_cnt : '0;
    assign out_last  = out_valid && (rd_cnt == LAST);
endmodule
